// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the TX framer state encoding.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int          ETH_MIN_FRAME = 60;
    localparam logic [31:0] ETH_CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT  = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS
    } eth_state_e;

endpackage

// File: rtl/eth_tx_framer_crc32_d8.sv
// Combinational reflected CRC-32 step over one byte (LSB first); shared with the RX FCS checker.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble/SFD, payload pass-through, optional zero padding, FCS.
// Padding to MIN_FRAME is built only when ETH_TX_PAD_EN is defined.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = ETH_MIN_FRAME
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    input  logic       m_tready,
    output logic       tx_underrun
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN);

    // The byte counter is 6 bits wide and the preamble counter 8 bits wide.
    if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 255 || MIN_FRAME < 1 || MIN_FRAME > 63) begin : g_bad_params
        $error("eth_tx_framer: PREAMBLE_LEN or MIN_FRAME out of range");
    end

    eth_state_e  state, state_nxt;
    logic [7:0]  pre_cnt, pre_cnt_nxt;
    logic [1:0]  fcs_idx, fcs_idx_nxt;
    logic [31:0] crc, crc_nxt, crc_upd, crc_fcs;
    logic [7:0]  crc_byte;
    logic [7:0]  tdata_nxt;
    logic        tvalid_nxt, tlast_nxt, underrun_nxt;
    logic        adv;

`ifdef ETH_TX_PAD_EN
    localparam logic [6:0] MIN_CNT = 7'(MIN_FRAME);

    logic [5:0] byte_cnt, byte_cnt_nxt;

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        if ({1'b0, v} >= MIN_CNT) return v;
        return v + 6'd1;
    endfunction
`endif

    assign adv      = !m_tvalid || m_tready;
    assign s_tready = (state == DATA) && adv;
    assign crc_byte = (state == PAD) ? 8'h00 : s_tdata;
    assign crc_fcs  = ~crc;

    eth_crc32_d8 u_crc (
        .crc      (crc),
        .data     (crc_byte),
        .crc_next (crc_upd)
    );

    always_comb begin
        state_nxt    = state;
        pre_cnt_nxt  = pre_cnt;
        fcs_idx_nxt  = fcs_idx;
        crc_nxt      = crc;
        tdata_nxt    = m_tdata;
        tvalid_nxt   = m_tvalid;
        tlast_nxt    = m_tlast;
        underrun_nxt = 1'b0;
`ifdef ETH_TX_PAD_EN
        byte_cnt_nxt = byte_cnt;
`endif
        if (adv) begin
            tvalid_nxt = 1'b1;
            tlast_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    // A frame tail still in the output register drains first, leaving a one-cycle gap.
                    if (!m_tvalid && s_tvalid) begin
                        tdata_nxt   = ETH_PREAMBLE;
                        pre_cnt_nxt = 8'd1;
                        state_nxt   = (PRE_LAST == 8'd1) ? SFD : PRE;
                    end else begin
                        tvalid_nxt = 1'b0;
                    end
                end
                PRE: begin
                    tdata_nxt   = ETH_PREAMBLE;
                    pre_cnt_nxt = pre_cnt + 8'd1;
                    if (pre_cnt + 8'd1 == PRE_LAST) state_nxt = SFD;
                end
                SFD: begin
                    tdata_nxt   = ETH_SFD;
                    crc_nxt     = ETH_CRC_INIT;
                    fcs_idx_nxt = 2'd0;
`ifdef ETH_TX_PAD_EN
                    byte_cnt_nxt = 6'd0;
`endif
                    state_nxt   = DATA;
                end
                DATA: begin
                    if (s_tvalid) begin
                        tdata_nxt = s_tdata;
                        crc_nxt   = crc_upd;
`ifdef ETH_TX_PAD_EN
                        byte_cnt_nxt = sat_inc(byte_cnt);
                        if (s_tlast) state_nxt = ({1'b0, byte_cnt} + 7'd1 < MIN_CNT) ? PAD : FCS;
`else
                        if (s_tlast) state_nxt = FCS;
`endif
                    end else begin
                        tvalid_nxt   = 1'b0;
                        underrun_nxt = 1'b1;
                    end
                end
`ifdef ETH_TX_PAD_EN
                PAD: begin
                    tdata_nxt    = 8'h00;
                    crc_nxt      = crc_upd;
                    byte_cnt_nxt = sat_inc(byte_cnt);
                    if ({1'b0, byte_cnt} + 7'd1 >= MIN_CNT) state_nxt = FCS;
                end
`endif
                FCS: begin
                    tdata_nxt   = crc_fcs[{fcs_idx, 3'b000} +: 8];
                    fcs_idx_nxt = fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        tlast_nxt = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    tvalid_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            fcs_idx     <= '0;
            crc         <= ETH_CRC_INIT;
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef ETH_TX_PAD_EN
            byte_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            pre_cnt     <= pre_cnt_nxt;
            fcs_idx     <= fcs_idx_nxt;
            crc         <= crc_nxt;
            m_tdata     <= tdata_nxt;
            m_tvalid    <= tvalid_nxt;
            m_tlast     <= tlast_nxt;
            tx_underrun <= underrun_nxt;
`ifdef ETH_TX_PAD_EN
            byte_cnt    <= byte_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: randomized frames against a frame-level reference model.
module tb_eth_tx_framer;

    logic       aclk;
    logic       aresetn;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready;
    logic       tx_underrun;

`ifdef ETH_TX_PAD_EN
    localparam int PAD_TO = 60;
`else
    localparam int PAD_TO = 0;
`endif

    eth_tx_framer dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .tx_underrun (tx_underrun)
    );

    logic [8:0] src_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         got_t[$];
    int         rdy_t[$];
    logic [7:0] pay_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int und_cnt = 0;
    int src_sent = 0;
    int gap_at = 0;
    int gap_len = 0;
    int gap_left = 0;
    int first_vld_cyc = 0;
    int ready_mode = 0;
    bit arm_t0 = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Reference model: whole expected frame from the payload in pay_q.
    task automatic load_frame();
        logic [31:0] c;
        int          n;
        c = 32'hFFFFFFFF;
        n = pay_q.size();
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < n; i++) begin
            src_q.push_back({(i == n - 1), pay_q[i]});
            exp_q.push_back({1'b0, pay_q[i]});
            c = crc_step(c, pay_q[i]);
        end
        for (int i = n; i < PAD_TO; i++) begin
            exp_q.push_back({1'b0, 8'h00});
            c = crc_step(c, 8'h00);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), c[8*k +: 8]});
    endtask

    task automatic rand_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_logs();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
        rdy_t.delete();
        und_cnt = 0;
        src_sent = 0;
    endtask

    function automatic int tat(input int i);
        return (i >= 0 && i < got_t.size()) ? got_t[i] : -1;
    endfunction

    function automatic int rdy_in(input int lo, input int hi);
        int n;
        n = 0;
        foreach (rdy_t[i]) if (rdy_t[i] >= lo && rdy_t[i] < hi) n++;
        return n;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(negedge aclk);
            n++;
        end
        repeat (4) @(negedge aclk);
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
        chk({tag, "_idle_after"}, 32'(m_tvalid), 32'd0);
    endtask

    task automatic check_frame(input string tag);
        int nbad;
        int first;
        int n;
        nbad  = 0;
        first = -1;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                nbad++;
            end
        end
        if (first >= 0)
            chk($sformatf("%s_badbeats first=%0d got=%0h exp=%0h", tag, first, got_q[first], exp_q[first]),
                32'(nbad), 32'd0);
        else
            chk({tag, "_badbeats"}, 32'(nbad), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
        chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
    endtask

    // Upstream source: presents src_q bytes, pops on handshake, optional underrun gap.
    initial begin
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        s_tlast  = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn && s_tvalid && s_tready && src_q.size() > 0) begin
                src_q.delete(0);
                src_sent++;
                if (src_sent == gap_at) gap_left = gap_len;
            end
            @(posedge aclk);
            #1;
            if (gap_left > 0) begin
                s_tvalid = 1'b0;
                gap_left--;
            end else if (src_q.size() > 0) begin
                if (arm_t0 && !s_tvalid) begin
                    first_vld_cyc = cyc;
                    arm_t0 = 0;
                end
                s_tvalid = 1'b1;
                {s_tlast, s_tdata} = src_q[0];
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
        end
    end

    // Downstream sink: records beats, checks stall stability, drives m_tready.
    initial begin
        logic       stalled;
        logic [9:0] hold;
        stalled  = 1'b0;
        hold     = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (m_tvalid && m_tready) begin
                    got_q.push_back({m_tlast, m_tdata});
                    got_t.push_back(cyc);
                end
                if (s_tready) rdy_t.push_back(cyc);
                if (tx_underrun) und_cnt++;
                if (stalled) chk("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'(hold));
                if (m_tvalid && !m_tready) chk("stall_s_tready", 32'(s_tready), 32'd0);
                stalled = m_tvalid && !m_tready;
                hold    = {1'b1, m_tlast, m_tdata};
            end else begin
                stalled = 1'b0;
            end
            @(posedge aclk);
            #1;
            case (ready_mode)
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b1;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int len1;
        int n;
        int span;

        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk_reset_outputs("reset");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // "123456789" with m_tready held high: latency, beat count, FCS
        clear_logs();
        pay_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        arm_t0 = 1;
        load_frame();
        wait_done("t1", 400);
        check_frame("t1");
        chk("t1_beats", 32'(got_q.size()), 32'(7 + 1 + ((9 > PAD_TO) ? 9 : PAD_TO) + 4));
        t0 = first_vld_cyc;
        chk("t1_lat_first_pre", 32'(tat(0) - t0), 32'd1);
        chk("t1_lat_sfd", 32'(tat(7) - t0), 32'd8);
        chk("t1_lat_data", 32'(tat(8) - t0), 32'd9);
        chk("t1_s_tready_first", 32'((rdy_t.size() > 0) ? rdy_t[0] - t0 : -1), 32'd8);
`ifndef ETH_TX_PAD_EN
        if (got_q.size() == 21)
            chk("t1_fcs_bytes", {got_q[17][7:0], got_q[18][7:0], got_q[19][7:0], got_q[20][7:0]}, 32'h2639F4CB);
`endif
        chk("t1_underrun", 32'(und_cnt), 32'd0);

        // 1-byte frame immediately followed by a 64-byte frame
        clear_logs();
        rand_payload(1);
        load_frame();
        rand_payload(64);
        load_frame();
        wait_done("t2", 800);
        check_frame("t2");
        len1 = 7 + 1 + ((1 > PAD_TO) ? 1 : PAD_TO) + 4;
        chk("t2_interframe_gap", 32'(tat(len1) - tat(len1 - 1)), 32'd2);
        chk("t2_s_tready_between", 32'(rdy_in(tat(8), tat(len1 + 7))), 32'd0);
        chk("t2_s_tready_frame2", 32'(rdy_in(tat(len1 + 7), tat(len1 + 7) + 1)), 32'd1);

        // 60-byte frame with m_tready toggling 1010...
        clear_logs();
        ready_mode = 1;
        rand_payload(60);
        load_frame();
        wait_done("t3", 800);
        check_frame("t3");
        ready_mode = 0;
        repeat (2) @(negedge aclk);

        // s_tvalid low for 3 cycles after byte 10
        clear_logs();
        gap_at  = 10;
        gap_len = 3;
        rand_payload(30);
        load_frame();
        wait_done("t4", 800);
        check_frame("t4");
        chk("t4_underrun_pulses", 32'(und_cnt), 32'd3);
        n    = got_t.size();
        span = (n > 0) ? (tat(n - 1) - tat(0) + 1 - n) : -1;
        chk("t4_m_tvalid_gaps", 32'(span), 32'd3);
        gap_at = 0;

        // Random lengths, random m_tready, back-to-back
        clear_logs();
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            rand_payload($urandom_range(1, 80));
            load_frame();
        end
        wait_done("t5", 3000);
        check_frame("t5");
        chk("t5_underrun", 32'(und_cnt), 32'd0);
        ready_mode = 0;
        repeat (2) @(negedge aclk);

        // Asynchronous reset during byte 20, then a clean frame
        clear_logs();
        rand_payload(40);
        load_frame();
        n = 0;
        while (got_q.size() < 28 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        chk("t6_reach_byte20", 32'(n < 400), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("t6_async_reset");
        src_q.delete();
        gap_left = 0;
        repeat (3) @(negedge aclk);
        clear_logs();
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        rand_payload(20);
        arm_t0 = 1;
        load_frame();
        wait_done("t6", 400);
        check_frame("t6");
        chk("t6_lat_first_pre", 32'(tat(0) - first_vld_cyc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
